// File: rtl/memctrl_req_master_if.sv
// rtl/memctrl_req_master_if.sv - command, response and MEMCTRL strobe bundle for memctrl_req_master
// master is the sequencer's view; slave is the surrounding environment's view.
interface memctrl_req_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [15:0] ADDR;
    logic        CE;
    logic        CSB;
    logic        WEB;
    logic        OEB;
    logic [7:0]  IDATA;
    logic [7:0]  ODATA;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, ODATA,
        output cmd_ready, rsp_valid, rsp_data, ADDR, CE, CSB, WEB, OEB, IDATA
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, ODATA,
        input  cmd_ready, rsp_valid, rsp_data, ADDR, CE, CSB, WEB, OEB, IDATA
    );
endinterface

// File: rtl/memctrl_req_master.sv
// rtl/memctrl_req_master.sv - MEMCTRL command sequencer: FIFO, strobe FSM, read capture
// Optional perf counters enabled by MEMCTRL_REQ_PERF_CNT_EN.
module memctrl_req_master #(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    memctrl_req_master_if.master     bus,
    output logic                     busy,
    output logic [15:0]              wr_cnt,
    output logic [15:0]              rd_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, RWAIT} state_t;

    logic [24:0] fifo_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push;
    logic [24:0] head;

    state_t      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic        cur_we_q;
    logic        cmd_done, capture, can_issue, launch;

    logic        ce_q, ce_d, csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  idata_q, idata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        busy_q, busy_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = bus.cmd_valid && !fifo_full;
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];

    // A read must not launch on a capture edge: its response slot would still be occupied.
    always_comb begin
        cmd_done  = ((state_q == GAP) && (cur_we_q || (RD_LAT == 1))) ||
                    ((state_q == RWAIT) && (wait_q == 2'd0));
        capture   = cmd_done && !cur_we_q;
        can_issue = !fifo_empty &&
                    (head[24] || ((!rsp_valid_q || bus.rsp_ready) && !capture));
        launch    = ((state_q == IDLE) || cmd_done) && can_issue;
        state_d   = state_q;
        wait_d    = wait_q;
        case (state_q)
            IDLE:    if (launch) state_d = ISSUE;
            ISSUE: begin
                state_d = GAP;
                wait_d  = WAIT_INIT;
            end
            default: begin
                if (launch)        state_d = ISSUE;
                else if (cmd_done) state_d = IDLE;
                else               state_d = RWAIT;
                if (state_q == RWAIT && !cmd_done) wait_d = wait_q - 2'd1;
            end
        endcase
    end

    always_comb begin
        ce_d        = launch;
        csb_d       = !launch;
        web_d       = !(launch && head[24]);
        oeb_d       = !(launch && !head[24]);
        addr_d      = launch ? head[23:8] : addr_q;
        idata_d     = (launch && head[24]) ? head[7:0] : 8'h00;
        rsp_valid_d = capture || (rsp_valid_q && !bus.rsp_ready);
        rsp_data_d  = capture ? bus.ODATA : rsp_data_q;
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(launch);
        busy_d      = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            wait_q      <= 2'd0;
            cur_we_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ce_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            addr_q      <= 16'h0000;
            idata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            if (launch) cur_we_q <= head[24];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ce_q        <= ce_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            addr_q      <= addr_d;
            idata_q     <= idata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
    end

`ifdef MEMCTRL_REQ_PERF_CNT_EN
    logic [15:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_cnt_q <= 16'h0000;
            rd_cnt_q <= 16'h0000;
        end else begin
            if (cmd_done && cur_we_q) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (capture)              rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`else
    assign wr_cnt = 16'h0000;
    assign rd_cnt = 16'h0000;
`endif

    assign bus.cmd_ready = !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.ADDR      = addr_q;
    assign bus.CE        = ce_q;
    assign bus.CSB       = csb_q;
    assign bus.WEB       = web_q;
    assign bus.OEB       = oeb_q;
    assign bus.IDATA     = idata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_memctrl_req_master.sv
// tb/tb_memctrl_req_master.sv - scoreboard bench for memctrl_req_master (RD_LAT=1 and RD_LAT=3 instances)
module tb_memctrl_req_master;
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } strobe_t;

`ifdef MEMCTRL_REQ_PERF_CNT_EN
    localparam logic [15:0] EXP_CNT1 = 16'd1;
`else
    localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

    logic        CLK = 1'b0;
    logic        RSTN, rstn3;
    logic        busy, busy3;
    logic [15:0] wr_cnt, rd_cnt, wr_cnt3, rd_cnt3;
    int          total = 0;
    int          bad = 0;

    strobe_t     sq[$];
    logic [7:0]  rq[$];
    logic [7:0]  mem [256];
    logic        rd_pend;
    logic [7:0]  rd_addr;
    logic [2:0]  pipe3;
    logic        prev_ce;

    memctrl_req_master_if bus();
    memctrl_req_master_if bus3();

    memctrl_req_master #(.DEPTH(4), .RD_LAT(1)) u_dut (
        .CLK(CLK), .RSTN(RSTN), .bus(bus), .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    memctrl_req_master #(.DEPTH(4), .RD_LAT(3)) u_dut3 (
        .CLK(CLK), .RSTN(rstn3), .bus(bus3), .busy(busy3), .wr_cnt(wr_cnt3), .rd_cnt(rd_cnt3)
    );

    always #5 CLK = ~CLK;

    // MEMCTRL models: data only valid in the cycle before the intended capture edge
    always @(posedge CLK) begin
        if (bus.CE && !bus.CSB && !bus.WEB) mem[bus.ADDR[7:0]] <= bus.IDATA;
        rd_pend <= bus.CE && !bus.CSB && !bus.OEB;
        if (bus.CE && !bus.CSB && !bus.OEB) rd_addr <= bus.ADDR[7:0];
        pipe3   <= {pipe3[1:0], bus3.CE && !bus3.CSB && !bus3.OEB};
    end
    assign bus.ODATA  = rd_pend ? mem[rd_addr] : 8'hEE;
    assign bus3.ODATA = pipe3[2] ? 8'h5A : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic check_strobe();
        strobe_t e;
        if (sq.size() == 0) begin
            timeout("unexpected_strobe");
        end else begin
            e = sq.pop_front();
            chk("strobe_addr", bus.ADDR, e.addr);
            chk("strobe_csb", bus.CSB, 0);
            chk("strobe_web", bus.WEB, !e.we);
            chk("strobe_oeb", bus.OEB, e.we);
            chk("strobe_idata", bus.IDATA, e.we ? e.data : 8'h00);
        end
    endtask

    task automatic check_rsp();
        logic [7:0] d;
        if (rq.size() == 0) begin
            timeout("unexpected_response");
        end else begin
            d = rq.pop_front();
            chk("rsp_data", bus.rsp_data, d);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTN === 1'b1 && bus.CE === 1'b1) begin
            chk("no_back_to_back", prev_ce, 0);
            check_strobe();
        end
        if (RSTN === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) check_rsp();
        prev_ce <= (bus.CE === 1'b1);
    end

    task automatic push(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rd);
        int n;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        n = 0;
        @(negedge CLK);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) timeout("push_ready");
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        sq.push_back('{we: we, addr: addr, data: wdata});
        if (!we) rq.push_back(exp_rd);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ce"}, bus.CE, 0);
        chk({tag, "_csb"}, bus.CSB, 1);
        chk({tag, "_web"}, bus.WEB, 1);
        chk({tag, "_oeb"}, bus.OEB, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        RSTN = 1'b0; rstn3 = 1'b0;
        bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.rsp_ready = 1;
        bus3.cmd_valid = 0; bus3.cmd_we = 0; bus3.cmd_addr = 0; bus3.cmd_wdata = 0; bus3.rsp_ready = 0;

        repeat (4) begin
            @(posedge CLK); @(negedge CLK);
            check_idle("rst");
        end
        @(posedge CLK); #1; RSTN = 1'b1; rstn3 = 1'b1;
        @(negedge CLK); check_idle("rel0");
        @(negedge CLK); check_idle("rel1");
        chk("rst_addr", bus.ADDR, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_rd_cnt", rd_cnt, 0);

        // single write timing
        push(1'b1, 16'h0010, 8'hA5, 8'h00);
        @(negedge CLK); chk("nobypass_ce", bus.CE, 0); chk("queued_busy", busy, 1);
        @(negedge CLK);
        chk("wr_ce", bus.CE, 1); chk("wr_csb", bus.CSB, 0); chk("wr_web", bus.WEB, 0);
        chk("wr_addr", bus.ADDR, 16'h0010); chk("wr_idata", bus.IDATA, 8'hA5);
        @(negedge CLK);
        chk("gap_ce", bus.CE, 0); chk("gap_idata", bus.IDATA, 0); chk("gap_csb", bus.CSB, 1);
        chk("gap_addr", bus.ADDR, 16'h0010); chk("gap_busy", busy, 1);
        @(negedge CLK); chk("after_gap_busy", busy, 0);

        // write then read back, RD_LAT=1
        @(posedge CLK); #1; RSTN = 1'b0;
        @(posedge CLK); #1; RSTN = 1'b1;
        push(1'b1, 16'h0020, 8'h3C, 8'h00);
        push(1'b0, 16'h0020, 8'h00, 8'h3C);
        n = 0;
        @(negedge CLK);
        while (!(bus.CE && !bus.OEB) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) timeout("rd_issue");
        @(negedge CLK); chk("rd_gap_rsp_valid", bus.rsp_valid, 0);
        @(negedge CLK);
        chk("rd_rsp_valid", bus.rsp_valid, 1);
        chk("rd_rsp_data", bus.rsp_data, 8'h3C);
        chk("wr_cnt", wr_cnt, EXP_CNT1);
        chk("rd_cnt", rd_cnt, EXP_CNT1);

        // held response blocks the next read; FIFO fills behind it
        @(posedge CLK); #1; bus.rsp_ready = 1'b0;
        push(1'b0, 16'h0010, 8'h00, 8'hA5);
        n = 0;
        @(negedge CLK);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) timeout("r1_capture");
        push(1'b0, 16'h0020, 8'h00, 8'h3C);
        push(1'b1, 16'h0030, 8'h11, 8'h00);
        push(1'b1, 16'h0031, 8'h22, 8'h00);
        push(1'b1, 16'h0032, 8'h33, 8'h00);
        @(negedge CLK); chk("full_cmd_ready", bus.cmd_ready, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("held_ce", bus.CE, 0);
            chk("held_rsp_valid", bus.rsp_valid, 1);
            chk("held_rsp_data", bus.rsp_data, 8'hA5);
        end
        @(posedge CLK); #1; bus.rsp_ready = 1'b1;
        @(negedge CLK); chk("release_ce", bus.CE, 0);
        @(negedge CLK);
        chk("r2_ce", bus.CE, 1); chk("r2_oeb", bus.OEB, 0); chk("r2_addr", bus.ADDR, 16'h0020);
        push(1'b1, 16'h0033, 8'h44, 8'h00);
        push(1'b0, 16'h0032, 8'h00, 8'h33);
        n = 0;
        @(negedge CLK);
        while ((busy || bus.rsp_valid) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) timeout("drain");
        chk("strobe_queue_empty", sq.size(), 0);
        chk("rsp_queue_empty", rq.size(), 0);

        // RD_LAT=3 capture latency
        @(posedge CLK); #1;
        bus3.cmd_valid = 1'b1; bus3.cmd_we = 1'b0; bus3.cmd_addr = 16'h0050;
        @(posedge CLK); #1; bus3.cmd_valid = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!bus3.CE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) timeout("lat3_issue");
        chk("lat3_oeb", bus3.OEB, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("lat3_wait_rsp_valid", bus3.rsp_valid, 0);
            chk("lat3_wait_ce", bus3.CE, 0);
        end
        @(negedge CLK);
        chk("lat3_rsp_valid", bus3.rsp_valid, 1);
        chk("lat3_rsp_data", bus3.rsp_data, 8'h5A);
        @(posedge CLK); #1; bus3.rsp_ready = 1'b1;
        @(posedge CLK); #1; bus3.rsp_ready = 1'b0;

        // reset during RWAIT aborts the read
        bus3.cmd_valid = 1'b1; bus3.cmd_addr = 16'h0051;
        @(posedge CLK); #1; bus3.cmd_valid = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!bus3.CE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) timeout("abort_issue");
        @(posedge CLK); #1;
        @(posedge CLK); #1; rstn3 = 1'b0;
        @(posedge CLK); #1; rstn3 = 1'b1;
        @(negedge CLK);
        chk("abort_ce", bus3.CE, 0); chk("abort_csb", bus3.CSB, 1);
        chk("abort_oeb", bus3.OEB, 1); chk("abort_web", bus3.WEB, 1);
        chk("abort_busy", busy3, 0); chk("abort_cmd_ready", bus3.cmd_ready, 1);
        repeat (6) begin
            @(negedge CLK);
            chk("abort_no_rsp", bus3.rsp_valid, 0);
            chk("abort_no_strobe", bus3.CE, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memctrl_req_master.md
Name: memctrl_req_master

Overview:
- Upstream command sequencer for MEMCTRL.
- Accepts read/write requests on a valid/ready command port and buffers them in a small FIFO.
- Converts each request into the MEMCTRL strobe protocol: one-cycle active strobe, then one-cycle idle gap.
- Captures read data from ODATA and returns it on a valid/ready response port.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- RD_LAT, 1, clock edges from the end of a read ISSUE cycle to the ODATA capture edge; range 1..4.

Ports:
- CLK  input  1  system clock, rising edge.
- RSTN  input  1  synchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO not full.
- cmd_we  input  1  1=write, 0=read.
- cmd_addr  input  16  target address.
- cmd_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  read data held in response register.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  8  read data.
- ADDR  output  16  to MEMCTRL ADDR.
- CE  output  1  to MEMCTRL CE.
- CSB  output  1  to MEMCTRL CSB.
- WEB  output  1  to MEMCTRL WEB.
- OEB  output  1  to MEMCTRL OEB.
- IDATA  output  8  to MEMCTRL IDATA.
- ODATA  input  8  from MEMCTRL ODATA.
- busy  output  1  FSM not IDLE or FIFO non-empty.
- wr_cnt  output  16  completed writes (see Optional Feature).
- rd_cnt  output  16  completed reads (see Optional Feature).

Behaviour:
- Reset:
  - All outputs are registered.
  - RSTN=0 sampled at a rising edge gives, from the next cycle: CE=0, CSB=1, WEB=1, OEB=1, ADDR=0, IDATA=0, rsp_valid=0, rsp_data=0, busy=0, counters=0.
  - FIFO is flushed; cmd_ready=1 once RSTN=1.
  - A reset mid-operation aborts any in-flight strobe and read capture; no response is produced for it.
- FIFO:
  - Push when cmd_valid & cmd_ready. cmd_ready = !full.
  - No bypass: an entry pushed at edge N can be issued no earlier than the cycle after edge N.
  - Simultaneous push and pop are allowed when not full.
  - Pointers wrap modulo DEPTH; a full/empty distinction bit is required.
- FSM states: IDLE, ISSUE, GAP, RWAIT.
  - IDLE -> ISSUE when FIFO is non-empty, and for a read also rsp_valid=0 (or rsp_ready=1 in that same cycle). Pops the head entry.
  - Reads are never issued while the response register would still be occupied at capture time, so capture never stalls.
  - ISSUE, one cycle: CE=1, CSB=0, ADDR=entry addr.
    - Write: WEB=0, OEB=1, IDATA=wdata.
    - Read: WEB=1, OEB=0, IDATA=0.
  - ISSUE -> GAP unconditionally.
  - GAP, one cycle: CE=0, CSB=1, WEB=1, OEB=1, IDATA=0, ADDR held.
  - GAP -> IDLE for a write, or for a read with RD_LAT=1. Otherwise GAP -> RWAIT, which lasts RD_LAT-1 cycles with the idle strobe pattern.
  - No back-to-back ISSUE: at least one GAP cycle always separates strobes.
- Read capture:
  - ODATA is sampled at the edge RD_LAT edges after the end of ISSUE.
  - At that same edge: rsp_data <= ODATA, rsp_valid <= 1.
  - rsp_valid clears at the edge where rsp_ready=1; rsp_data is held until the next capture.
- Throughput:
  - Write: 2 cycles per command.
  - Read: 1+RD_LAT cycles, plus any wait for response acceptance.
- busy=1 whenever state != IDLE or the FIFO is non-empty.

Optional Feature:
- Macro: MEMCTRL_REQ_PERF_CNT_EN.
- Defined:
  - wr_cnt increments at the end of each write GAP.
  - rd_cnt increments at each read capture edge.
  - Both are 16-bit, wrap 0xFFFF->0, and are cleared by reset.
- Undefined: wr_cnt and rd_cnt are tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset with RSTN=0 for 4 cycles -> CSB=1, WEB=1, OEB=1, CE=0, rsp_valid=0, cmd_ready=1 throughout and after release.
- Single write addr=0x0010, wdata=0xA5 into an idle block -> ISSUE exactly one cycle later with CE=1, CSB=0, WEB=0, ADDR=0x0010, IDATA=0xA5; next cycle CE=0, IDATA=0; busy drops after GAP.
- Write 0x3C to 0x0020 then read 0x0020, RD_LAT=1, rsp_ready=1 -> read ISSUE has OEB=0; rsp_valid=1 with rsp_data=0x3C one cycle after the read GAP edge; wr_cnt=1, rd_cnt=1 with the macro, 0 without.
- Push 6 commands with DEPTH=4 while the FSM is busy -> cmd_ready low after the 4th queued entry; all 6 are issued in order, separated by GAP cycles.
- Two reads with rsp_ready=0 -> the first response is held; the second read ISSUE does not occur until the cycle rsp_ready=1; no data is lost.
- Reset asserted during a read RWAIT with RD_LAT=3 -> no rsp_valid, FIFO empty, strobes idle the cycle after reset is sampled.
